packet_gen_axis_cfg: RTL and testbench

PACKET_GEN_AXIS_CFG -- requirements
Module: packet_gen_axis_cfg

---
 rtl/packet_gen_pkg.sv | 27 ++
 rtl/prbs32_lfsr.sv | 27 ++
 rtl/packet_gen_axis_cfg.sv | 176 +++++++++++++++++
 tb/tb_packet_gen_axis_cfg.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_gen_pkg.sv
// Shared types and constants for the AXI-Stream packet generator.
// Includes the single-step Galois LFSR update used by the PRBS payload.
package packet_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

  // Right-shifting Galois form: the bit shifted out of bit 0 selects the XOR mask.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/prbs32_lfsr.sv
// 32-bit Galois LFSR with a synchronous load-to-seed and a step enable.
// Load takes priority over advance.
module prbs32_lfsr
  import packet_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] state
);

  logic [31:0] state_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= LFSR_SEED;
    end else if (load) begin
      state_reg <= LFSR_SEED;
    end else if (advance) begin
      state_reg <= lfsr_step(state_reg);
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/packet_gen_axis_cfg.sv
// Configurable AXI-Stream packet generator: INCR / PRBS / CONST payloads,
// programmable length, inter-packet gap and packet count per run.
module packet_gen_axis_cfg
  import packet_gen_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16,
  parameter int GAP_WIDTH   = 8
) (
  input  logic                   axis_aclk,
  input  logic                   axis_areset,
  input  logic                   enable,
  input  logic [1:0]             cfg_mode,
  input  logic [LEN_WIDTH-1:0]   cfg_len,
  input  logic [GAP_WIDTH-1:0]   cfg_gap,
  input  logic [15:0]            cfg_pkt_count,
  input  logic [TDATA_WIDTH-1:0] cfg_pattern,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            pkt_sent
);

  state_e                 state_reg;
  mode_e                  mode_reg;
  logic [LEN_WIDTH-1:0]   rem_reg;
  logic [LEN_WIDTH-1:0]   byte_off_reg;
  logic [GAP_WIDTH-1:0]   gap_lat_reg;
  logic [GAP_WIDTH-1:0]   gap_cnt_reg;
  logic [15:0]            cnt_lat_reg;
  logic [15:0]            run_cnt_reg;
  logic [TDATA_WIDTH-1:0] pattern_reg;
  logic [31:0]            pkt_sent_reg;
  logic [31:0]            lfsr_state;

  logic                   valid;
  logic                   accept;
  logic                   last_beat;
  logic                   pkt_done;
  logic                   count_hit;
  logic                   start_pkt;
  logic                   run_start;
  logic [LEN_WIDTH-1:0]   cfg_len_eff;
  logic [7:0]             incr_base;

  assign valid       = (state_reg == ST_SEND);
  assign accept      = valid & m_axis_tready;
  // rem_reg holds the bytes still to send, so the final beat is the one covering the rest.
  assign last_beat   = (rem_reg <= LEN_WIDTH'(TKEEP_WIDTH));
  assign pkt_done    = accept & last_beat;
  assign count_hit   = (cnt_lat_reg != 16'd0) && ((run_cnt_reg + 16'd1) == cnt_lat_reg);
  assign run_start   = (state_reg == ST_IDLE) & enable;
  assign cfg_len_eff = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
  // pkt_sent is stable for the whole packet, so its low byte is the INCR seed.
  assign incr_base   = pkt_sent_reg[7:0] + byte_off_reg[7:0];

  always_comb begin
    start_pkt = 1'b0;
    case (state_reg)
      ST_IDLE: start_pkt = enable;
      ST_SEND: start_pkt = pkt_done & ~count_hit & enable & (gap_lat_reg == '0);
      ST_GAP:  start_pkt = (gap_cnt_reg <= GAP_WIDTH'(1)) & enable;
      default: start_pkt = 1'b0;
    endcase
  end

  prbs32_lfsr u_lfsr (
    .clk     (axis_aclk),
    .rst     (axis_areset),
    .load    (run_start),
    .advance (accept),
    .state   (lfsr_state)
  );

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_reg    <= ST_IDLE;
      mode_reg     <= MODE_INCR;
      rem_reg      <= '0;
      byte_off_reg <= '0;
      gap_lat_reg  <= '0;
      gap_cnt_reg  <= '0;
      cnt_lat_reg  <= '0;
      run_cnt_reg  <= '0;
      pattern_reg  <= '0;
      pkt_sent_reg <= '0;
    end else begin
      if (start_pkt) begin
        mode_reg     <= mode_e'(cfg_mode);
        rem_reg      <= cfg_len_eff;
        byte_off_reg <= '0;
        gap_lat_reg  <= cfg_gap;
        cnt_lat_reg  <= cfg_pkt_count;
        pattern_reg  <= cfg_pattern;
      end else if (accept && !last_beat) begin
        rem_reg      <= rem_reg - LEN_WIDTH'(TKEEP_WIDTH);
        byte_off_reg <= byte_off_reg + LEN_WIDTH'(TKEEP_WIDTH);
      end

      if (pkt_done) begin
        pkt_sent_reg <= pkt_sent_reg + 32'd1;
      end

      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_reg   <= ST_SEND;
            run_cnt_reg <= 16'd0;
          end
        end
        ST_SEND: begin
          if (pkt_done) begin
            run_cnt_reg <= run_cnt_reg + 16'd1;
            if (count_hit) begin
              state_reg <= ST_DONE;
            end else if (!enable) begin
              state_reg <= ST_IDLE;
            end else if (gap_lat_reg != '0) begin
              state_reg   <= ST_GAP;
              gap_cnt_reg <= gap_lat_reg;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg <= GAP_WIDTH'(1)) begin
            gap_cnt_reg <= '0;
            state_reg   <= enable ? ST_SEND : ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - GAP_WIDTH'(1);
          end
        end
        ST_DONE: begin
          if (!enable) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Per-byte lane formatting; lanes beyond the remaining length are zeroed.
  genvar gi;
  generate
    for (gi = 0; gi < TKEEP_WIDTH; gi++) begin : g_lane
      logic [7:0] byte_val;
      logic       keep;

      assign keep = valid && (rem_reg > LEN_WIDTH'(gi));

      always_comb begin
        byte_val = 8'h00;
        case (mode_reg)
          MODE_PRBS:  byte_val = lfsr_state[8*(gi%4) +: 8];
          MODE_CONST: byte_val = pattern_reg[8*gi +: 8];
          default:    byte_val = incr_base + 8'(gi);
        endcase
      end

      assign m_axis_tkeep[gi]        = keep;
      assign m_axis_tdata[8*gi +: 8] = keep ? byte_val : 8'h00;
    end
  endgenerate

  assign m_axis_tvalid = valid;
  assign m_axis_tlast  = valid & last_beat;
  assign busy          = (state_reg == ST_SEND) || (state_reg == ST_GAP);
  assign done          = (state_reg == ST_DONE);
  assign pkt_sent      = pkt_sent_reg;

endmodule

// File: tb/tb_packet_gen_axis_cfg.sv
// Directed bench for packet_gen_axis_cfg at the default 32-bit width.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_packet_gen_axis_cfg;

  logic        axis_aclk = 1'b0;
  logic        axis_areset;
  logic        enable;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_gap;
  logic [15:0] cfg_pkt_count;
  logic [31:0] cfg_pattern;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;
  logic        done;
  logic [31:0] pkt_sent;

  int errors = 0;
  int checks = 0;

  always #5 axis_aclk = ~axis_aclk;

  packet_gen_axis_cfg dut (
    .axis_aclk     (axis_aclk),
    .axis_areset   (axis_areset),
    .enable        (enable),
    .cfg_mode      (cfg_mode),
    .cfg_len       (cfg_len),
    .cfg_gap       (cfg_gap),
    .cfg_pkt_count (cfg_pkt_count),
    .cfg_pattern   (cfg_pattern),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .done          (done),
    .pkt_sent      (pkt_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [15:0] len, input logic [7:0] gap,
                         input logic [15:0] cnt, input logic [31:0] pat);
    cfg_mode      = m;
    cfg_len       = len;
    cfg_gap       = gap;
    cfg_pkt_count = cnt;
    cfg_pattern   = pat;
  endtask

  // Check the beat on the bus now (tready held high), then step one cycle.
  task automatic beat(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    chk({tag, "_valid"}, 32'(m_axis_tvalid), 32'd1);
    chk({tag, "_data"},  m_axis_tdata, d);
    chk({tag, "_keep"},  32'(m_axis_tkeep), 32'(k));
    chk({tag, "_last"},  32'(m_axis_tlast), 32'(l));
    $display("beat %s: tdata=%h tkeep=%h tlast=%0b", tag, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    @(negedge axis_aclk);
  endtask

  task automatic prbs_run(input string tag);
    set_cfg(2'd1, 16'd12, 8'd0, 16'd1, 32'h0);
    enable = 1'b1;
    @(negedge axis_aclk);
    beat({tag, "_b0"}, 32'hFFFF_FFFF, 4'hF, 1'b0);
    beat({tag, "_b1"}, 32'hFFDF_FFFC, 4'hF, 1'b0);
    beat({tag, "_b2"}, 32'h7FEF_FFFE, 4'hF, 1'b1);
    chk({tag, "_done"}, 32'(done), 32'd1);
    enable = 1'b0;
    @(negedge axis_aclk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int   accepted;
    int   low;
    logic [31:0] held;

    axis_areset   = 1'b1;
    enable        = 1'b0;
    m_axis_tready = 1'b1;
    set_cfg(2'd0, 16'd0, 8'd0, 16'd0, 32'h0);
    @(negedge axis_aclk);
    @(negedge axis_aclk);

    // Reset state
    chk("rst_tvalid",   32'(m_axis_tvalid), 32'd0);
    chk("rst_tlast",    32'(m_axis_tlast), 32'd0);
    chk("rst_tdata",    m_axis_tdata, 32'd0);
    chk("rst_tkeep",    32'(m_axis_tkeep), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_done",     32'(done), 32'd0);
    chk("rst_pkt_sent", pkt_sent, 32'd0);
    axis_areset = 1'b0;
    @(negedge axis_aclk);

    // Two INCR packets of 10 bytes, back to back
    set_cfg(2'd0, 16'd10, 8'd0, 16'd2, 32'h0);
    enable = 1'b1;
    @(negedge axis_aclk);
    beat("incr_p0b0", 32'h0302_0100, 4'hF, 1'b0);
    beat("incr_p0b1", 32'h0706_0504, 4'hF, 1'b0);
    beat("incr_p0b2", 32'h0000_0908, 4'h3, 1'b1);
    beat("incr_p1b0", 32'h0403_0201, 4'hF, 1'b0);
    beat("incr_p1b1", 32'h0807_0605, 4'hF, 1'b0);
    beat("incr_p1b2", 32'h0000_0A09, 4'h3, 1'b1);
    chk("incr_done",     32'(done), 32'd1);
    chk("incr_busy",     32'(busy), 32'd0);
    chk("incr_tvalid",   32'(m_axis_tvalid), 32'd0);
    chk("incr_pkt_sent", pkt_sent, 32'd2);
    enable = 1'b0;
    @(negedge axis_aclk);
    chk("idle_done", 32'(done), 32'd0);

    // Unlimited count with a 3-cycle gap; enable dropped on the last beat skips the gap
    set_cfg(2'd0, 16'd8, 8'd3, 16'd0, 32'h0);
    enable = 1'b1;
    @(negedge axis_aclk);
    beat("gap_p0b0", 32'h0504_0302, 4'hF, 1'b0);
    beat("gap_p0b1", 32'h0908_0706, 4'hF, 1'b1);
    low = 0;
    while (!m_axis_tvalid && low < 20) begin
      chk("gap_busy", 32'(busy), 32'd1);
      low++;
      @(negedge axis_aclk);
    end
    chk("gap_cycles", 32'(low), 32'd3);
    beat("gap_p1b0", 32'h0605_0403, 4'hF, 1'b0);
    enable = 1'b0;
    beat("gap_p1b1", 32'h0A09_0807, 4'hF, 1'b1);
    chk("gap_stop_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("gap_stop_busy",   32'(busy), 32'd0);
    chk("gap_pkt_sent",    pkt_sent, 32'd4);
    @(negedge axis_aclk);

    // CONST packet with backpressure
    set_cfg(2'd2, 16'd16, 8'd0, 16'd1, 32'hA5A5_A5A5);
    enable = 1'b1;
    @(negedge axis_aclk);
    accepted = 0;
    held = m_axis_tdata;
    for (int i = 0; i < 6; i++) begin
      m_axis_tready = rdy_seq[i];
      chk("const_valid", 32'(m_axis_tvalid), 32'd1);
      chk("const_data",  m_axis_tdata, 32'hA5A5_A5A5);
      chk("const_stable", m_axis_tdata, held);
      chk("const_last",  32'(m_axis_tlast), 32'(accepted == 3));
      $display("const cycle %0d: tready=%0b tdata=%h tlast=%0b", i, m_axis_tready, m_axis_tdata, m_axis_tlast);
      if (m_axis_tvalid && m_axis_tready) accepted++;
      @(negedge axis_aclk);
    end
    m_axis_tready = 1'b1;
    chk("const_accepted", 32'(accepted), 32'd4);
    chk("const_done",     32'(done), 32'd1);
    chk("const_tvalid",   32'(m_axis_tvalid), 32'd0);
    chk("const_pkt_sent", pkt_sent, 32'd5);
    enable = 1'b0;
    @(negedge axis_aclk);

    // PRBS run, then reset and rerun for the same sequence
    prbs_run("prbs1");
    axis_areset = 1'b1;
    @(negedge axis_aclk);
    chk("prbs_rst_pkt_sent", pkt_sent, 32'd0);
    axis_areset = 1'b0;
    @(negedge axis_aclk);
    prbs_run("prbs2");
    chk("prbs_pkt_sent", pkt_sent, 32'd1);

    // Enable dropped mid-packet: packet completes, no gap follows
    set_cfg(2'd0, 16'd20, 8'd2, 16'd0, 32'h0);
    enable = 1'b1;
    @(negedge axis_aclk);
    beat("drop_b0", 32'h0403_0201, 4'hF, 1'b0);
    enable = 1'b0;
    beat("drop_b1", 32'h0807_0605, 4'hF, 1'b0);
    beat("drop_b2", 32'h0C0B_0A09, 4'hF, 1'b0);
    beat("drop_b3", 32'h100F_0E0D, 4'hF, 1'b0);
    beat("drop_b4", 32'h1413_1211, 4'hF, 1'b1);
    chk("drop_tvalid",   32'(m_axis_tvalid), 32'd0);
    chk("drop_busy",     32'(busy), 32'd0);
    chk("drop_pkt_sent", pkt_sent, 32'd2);

    // Asynchronous reset mid-packet
    set_cfg(2'd0, 16'd10, 8'd0, 16'd0, 32'h0);
    enable = 1'b1;
    @(negedge axis_aclk);
    beat("arst_b0", 32'h0504_0302, 4'hF, 1'b0);
    chk("arst_pre_valid", 32'(m_axis_tvalid), 32'd1);
    axis_areset = 1'b1;
    #1;
    chk("arst_tvalid",   32'(m_axis_tvalid), 32'd0);
    chk("arst_tdata",    m_axis_tdata, 32'd0);
    chk("arst_busy",     32'(busy), 32'd0);
    chk("arst_pkt_sent", pkt_sent, 32'd0);
    enable = 1'b0;
    @(negedge axis_aclk);
    axis_areset = 1'b0;
    @(negedge axis_aclk);
    set_cfg(2'd0, 16'd8, 8'd0, 16'd1, 32'h0);
    enable = 1'b1;
    @(negedge axis_aclk);
    beat("rerun_b0", 32'h0302_0100, 4'hF, 1'b0);
    beat("rerun_b1", 32'h0706_0504, 4'hF, 1'b1);
    chk("rerun_done", 32'(done), 32'd1);
    enable = 1'b0;
    @(negedge axis_aclk);

    // Zero length is sent as a single byte
    set_cfg(2'd0, 16'd0, 8'd0, 16'd1, 32'h0);
    enable = 1'b1;
    @(negedge axis_aclk);
    beat("len0_b0", 32'h0000_0001, 4'h1, 1'b1);
    chk("len0_done",     32'(done), 32'd1);
    chk("len0_pkt_sent", pkt_sent, 32'd2);
    enable = 1'b0;
    @(negedge axis_aclk);
    chk("final_done", 32'(done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
